// File: rtl/exec_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module   : exec_alu_unit (with mux_2to1_n and exec_alu_core)
//  Brief    : Execute-stage ALU. Operand-B select, 16-op combinational core,
//             and one registered result/overflow stage with stall bubbles.
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  mux_2to1_n : generic n-bit 2:1 multiplexer (out = sel ? in1 : in0)
// ----------------------------------------------------------------------------
module mux_2to1_n #(
    parameter int n = 32
) (
    input  logic [n-1:0] in0,
    input  logic [n-1:0] in1,
    input  logic         sel,
    output logic [n-1:0] out
);

    // Pure select; no state.
    assign out = sel ? in1 : in0;

endmodule

// ----------------------------------------------------------------------------
//  exec_alu_core : combinational ALU, result plus signed-overflow flag
// ----------------------------------------------------------------------------
module exec_alu_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int c_S = $clog2(WIDTH);

    localparam logic [3:0] c_OP_ADD   = 4'h0;
    localparam logic [3:0] c_OP_SUB   = 4'h1;
    localparam logic [3:0] c_OP_AND   = 4'h2;
    localparam logic [3:0] c_OP_OR    = 4'h3;
    localparam logic [3:0] c_OP_XOR   = 4'h4;
    localparam logic [3:0] c_OP_NOR   = 4'h5;
    localparam logic [3:0] c_OP_SLL   = 4'h6;
    localparam logic [3:0] c_OP_SRL   = 4'h7;
    localparam logic [3:0] c_OP_SRA   = 4'h8;
    localparam logic [3:0] c_OP_SLT   = 4'h9;
    localparam logic [3:0] c_OP_SLTU  = 4'hA;
    localparam logic [3:0] c_OP_SEQ   = 4'hB;
    localparam logic [3:0] c_OP_SNE   = 4'hC;
    localparam logic [3:0] c_OP_SGE   = 4'hD;
    localparam logic [3:0] c_OP_LHI   = 4'hE;
    localparam logic [3:0] c_OP_PASSB = 4'hF;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [c_S-1:0]   w_shamt;
    logic             w_slt;
    logic             w_sltu;
    logic             w_ovf_add;
    logic             w_ovf_sub;

    // Only the low log2(WIDTH) bits of B form the shift amount.
    assign w_shamt = B[c_S-1:0];
    // Carries out of the top bit fall off: arithmetic is modulo 2^WIDTH.
    assign w_sum   = A + B;
    assign w_diff  = A - B;
    assign w_slt   = ($signed(A) < $signed(B));
    assign w_sltu  = (A < B);

    // ADD overflows when like-signed operands give an opposite-signed sum;
    // SUB overflows when unlike-signed operands give a result whose sign differs from A.
    assign w_ovf_add = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1]  != A[WIDTH-1]);
    assign w_ovf_sub = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);

    // Opcode decode; set-type results are zero-extended single bits.
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (ctrl)
            c_OP_ADD:   begin result = w_sum;  ovf = w_ovf_add; end
            c_OP_SUB:   begin result = w_diff; ovf = w_ovf_sub; end
            c_OP_AND:   result = A & B;
            c_OP_OR:    result = A | B;
            c_OP_XOR:   result = A ^ B;
            c_OP_NOR:   result = ~(A | B);
            c_OP_SLL:   result = A << w_shamt;
            c_OP_SRL:   result = A >> w_shamt;
            c_OP_SRA:   result = $unsigned($signed(A) >>> w_shamt);
            c_OP_SLT:   result = {{(WIDTH-1){1'b0}}, w_slt};
            c_OP_SLTU:  result = {{(WIDTH-1){1'b0}}, w_sltu};
            c_OP_SEQ:   result = {{(WIDTH-1){1'b0}}, (A == B)};
            c_OP_SNE:   result = {{(WIDTH-1){1'b0}}, (A != B)};
            c_OP_SGE:   result = {{(WIDTH-1){1'b0}}, ~w_slt};
            c_OP_LHI:   result = B << (WIDTH/2);
            c_OP_PASSB: result = B;
            default:    result = '0;
        endcase
    end

endmodule

// ----------------------------------------------------------------------------
//  exec_alu_unit : top level, operand select + core + output register
// ----------------------------------------------------------------------------
module exec_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             ALUSrc,
    input  logic [3:0]       AluCtrl,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic [WIDTH-1:0] Imm32,
    output logic [WIDTH-1:0] ALUout,
    output logic             Ovf
);

    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf;
    logic [WIDTH-1:0] alu_out_d;
    logic [WIDTH-1:0] alu_out_q;
    logic             ovf_d;
    logic             ovf_q;

    mux_2to1_n #(
        .n   (WIDTH)
    ) u_opb_mux (
        .in0 (BusB),
        .in1 (Imm32),
        .sel (ALUSrc),
        .out (w_opb)
    );

    exec_alu_core #(
        .WIDTH  (WIDTH)
    ) u_core (
        .A      (BusA),
        .B      (w_opb),
        .ctrl   (AluCtrl),
        .result (w_result),
        .ovf    (w_ovf)
    );

    // Next state: a stall injects a zero bubble, otherwise take the core result.
    always_comb begin
        alu_out_d = w_result;
        ovf_d     = w_ovf;
        if (stall) begin
            alu_out_d = '0;
            ovf_d     = 1'b0;
        end
    end

    // Output register; synchronous active-low reset dominates the stall bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            alu_out_q <= alu_out_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ALUout = alu_out_q;
    assign Ovf    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exec_alu_unit
//  Brief    : Directed self-checking bench for exec_alu_unit with an
//             expected-result queue filled at drive time and drained after
//             each capturing edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exec_alu_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             ALUSrc;
    logic [3:0]       AluCtrl;
    logic [WIDTH-1:0] BusA;
    logic [WIDTH-1:0] BusB;
    logic [WIDTH-1:0] Imm32;
    logic [WIDTH-1:0] ALUout;
    logic             Ovf;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] res;
        logic             ovf;
    } exp_t;

    exp_t sb_q[$];
    int   total;
    int   bad;

    exec_alu_unit #(
        .WIDTH   (WIDTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .stall   (stall),
        .ALUSrc  (ALUSrc),
        .AluCtrl (AluCtrl),
        .BusA    (BusA),
        .BusB    (BusB),
        .Imm32   (Imm32),
        .ALUout  (ALUout),
        .Ovf     (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one set of inputs on the falling edge and queue the expectation.
    task automatic drive(input string tag, input logic rst, input logic stl,
                         input logic src, input logic [3:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] imm,
                         input logic [WIDTH-1:0] eres, input logic eovf);
        exp_t e;
        @(negedge clk);
        rst_n   = rst;
        stall   = stl;
        ALUSrc  = src;
        AluCtrl = op;
        BusA    = a;
        BusB    = b;
        Imm32   = imm;
        e.tag = tag;
        e.res = eres;
        e.ovf = eovf;
        sb_q.push_back(e);
    endtask

    // Let the capturing edge pass, then pop and compare away from the edge.
    task automatic check();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty: observed=0 entries required=1");
        end else begin
            e = sb_q.pop_front();
            total++;
            assert (ALUout === e.res) else begin
                bad++;
                $error("FAIL %s.ALUout: observed=%h expected=%h", e.tag, ALUout, e.res);
            end
            total++;
            assert (Ovf === e.ovf) else begin
                bad++;
                $error("FAIL %s.Ovf: observed=%b expected=%b", e.tag, Ovf, e.ovf);
            end
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic stl,
                        input logic src, input logic [3:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] imm,
                        input logic [WIDTH-1:0] eres, input logic eovf);
        drive(tag, rst, stl, src, op, a, b, imm, eres, eovf);
        check();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        stall   = 1'b0;
        ALUSrc  = 1'b0;
        AluCtrl = 4'h0;
        BusA    = '0;
        BusB    = '0;
        Imm32   = '0;

        // Reset
        step("reset",        1'b0, 1'b0, 1'b0, 4'h0, 32'd5, 32'd3, 32'd0, 32'h0, 1'b0);
        // Arithmetic and overflow
        step("add_ovf",      1'b1, 1'b0, 1'b0, 4'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h80000000, 1'b1);
        step("sub",          1'b1, 1'b0, 1'b0, 4'h1, 32'd5, 32'd3, 32'h0, 32'd2, 1'b0);
        step("add_imm",      1'b1, 1'b0, 1'b1, 4'h0, 32'h0, 32'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        step("add_negovf",   1'b1, 1'b0, 1'b0, 4'h0, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 1'b1);
        step("sub_ovf",      1'b1, 1'b0, 1'b0, 4'h1, 32'h80000000, 32'h1, 32'h0, 32'h7FFFFFFF, 1'b1);
        step("sub_noovf",    1'b1, 1'b0, 1'b0, 4'h1, 32'h80000000, 32'h80000000, 32'h0, 32'h0, 1'b0);
        // Logic ops (AND uses inputs that would overflow an ADD)
        step("and_noovf",    1'b1, 1'b0, 1'b0, 4'h2, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h7FFFFFFF, 1'b0);
        step("and",          1'b1, 1'b0, 1'b0, 4'h2, 32'h0000F0F0, 32'h0000FF00, 32'h0, 32'h0000F000, 1'b0);
        step("or",           1'b1, 1'b0, 1'b0, 4'h3, 32'h0000F0F0, 32'h0000FF00, 32'h0, 32'h0000FFF0, 1'b0);
        step("xor",          1'b1, 1'b0, 1'b0, 4'h4, 32'h0000F0F0, 32'h0000FF00, 32'h0, 32'h00000FF0, 1'b0);
        step("nor",          1'b1, 1'b0, 1'b0, 4'h5, 32'h0000F0F0, 32'h0000FF00, 32'h0, 32'hFFFF000F, 1'b0);
        // Shifts: upper shift-amount bits are ignored
        step("sll_mask",     1'b1, 1'b0, 1'b0, 4'h6, 32'h1, 32'h21, 32'h0, 32'h2, 1'b0);
        step("sra",          1'b1, 1'b0, 1'b0, 4'h8, 32'h80000000, 32'h24, 32'h0, 32'hF8000000, 1'b0);
        step("srl",          1'b1, 1'b0, 1'b0, 4'h7, 32'h80000000, 32'h24, 32'h0, 32'h08000000, 1'b0);
        step("lhi",          1'b1, 1'b0, 1'b0, 4'hE, 32'h80000000, 32'h1234, 32'h0, 32'h12340000, 1'b0);
        // Compares
        step("slt",          1'b1, 1'b0, 1'b0, 4'h9, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1, 1'b0);
        step("sltu",         1'b1, 1'b0, 1'b0, 4'hA, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0);
        step("seq",          1'b1, 1'b0, 1'b0, 4'hB, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0);
        step("sne",          1'b1, 1'b0, 1'b0, 4'hC, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1, 1'b0);
        step("sge",          1'b1, 1'b0, 1'b0, 4'hD, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0);
        step("seq_eq",       1'b1, 1'b0, 1'b0, 4'hB, 32'd7, 32'd7, 32'h0, 32'h1, 1'b0);
        step("sge_true",     1'b1, 1'b0, 1'b0, 4'hD, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0);
        step("passb_imm",    1'b1, 1'b0, 1'b1, 4'hF, 32'h5, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        // Stall bubble after a valid ADD
        step("add_2p2",      1'b1, 1'b0, 1'b0, 4'h0, 32'd2, 32'd2, 32'h0, 32'd4, 1'b0);

        // Output holds between edges even when inputs move
        @(negedge clk);
        BusA = 32'h12345678;
        BusB = 32'h0F0F0F0F;
        #2;
        total++;
        assert (ALUout === 32'd4) else begin
            bad++;
            $error("FAIL hold: observed=%h expected=%h", ALUout, 32'd4);
        end

        step("stall_bubble", 1'b1, 1'b1, 1'b0, 4'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0);
        step("load_again",   1'b1, 1'b0, 1'b0, 4'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h80000000, 1'b1);
        step("rst_stall",    1'b0, 1'b1, 1'b0, 4'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 1'b0);
        step("rst_release",  1'b1, 1'b0, 1'b0, 4'h1, 32'd10, 32'd3, 32'h0, 32'd7, 1'b0);

        total++;
        assert (sb_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain: observed=%0d entries expected=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
